// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B computed LSB first through one borrow flop.
// Optional SERIAL_SUB_OVF_EN adds the OV (signed overflow) output.
module serial_subtractor #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BO,
`ifdef SERIAL_SUB_OVF_EN
  output logic             OV,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic             alive;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic [CW-1:0]    cnt;
  logic             bw, bw_nx, d_bit, last;
  logic             a_msb, b_msb;
  logic             accept;

  assign in_ready  = alive && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  // One full-subtractor slice; the new bit enters the result at the MSB.
  always_comb begin
    d_bit  = a_sh[0] ^ b_sh[0] ^ bw;
    bw_nx  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bw);
    res_nx = res_sh >> 1;
    res_nx[WIDTH-1] = d_bit;
    last   = (cnt == CW'(WIDTH-1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SHIFT;
      SHIFT:   if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // alive keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nx;
      alive <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      bw     <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
    end else if (accept) begin
      a_sh   <= A;
      b_sh   <= B;
      res_sh <= '0;
      cnt    <= '0;
      bw     <= 1'b0;
      a_msb  <= A[WIDTH-1];
      b_msb  <= B[WIDTH-1];
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nx;
      cnt    <= cnt + 1'b1;
      bw     <= bw_nx;
    end
  end

  // Visible result only changes on the final shift, so it holds through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D  <= '0;
      BO <= 1'b0;
    end else if (state == SHIFT && last) begin
      D  <= res_nx;
      BO <= bw_nx;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      OV <= 1'b0;
    else if (state == SHIFT && last)
      OV <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=2): directed, exhaustive,
// backpressure, abort-by-reset and input-stability scenarios.
module tb_serial_subtractor;
  localparam int W = 2;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, BO, busy;
  logic [W-1:0] A, B, D;
  logic         OV;

  int   n_chk = 0, n_pass = 0;
  int   cyc = 0;
  int   last_acc = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  exp_t mon_e;
  int   mon_a;
  logic ov_prev = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .D(D), .BO(BO),
`ifdef SERIAL_SUB_OVF_EN
    .OV(OV),
`endif
    .busy(busy)
  );
`ifndef SERIAL_SUB_OVF_EN
  assign OV = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive one operation; expected result derived from a WIDTH+1 bit subtract.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    logic [W:0] full;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ready_timeout", 0, 1);
    in_valid = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    full = {1'b0, a} - {1'b0, b};
    e.d  = full[W-1:0];
    e.bo = full[W];
    e.ov = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    last_acc = cyc;
    in_valid = 1'b0;
    A = W'($urandom); B = W'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", 0, 1);
  endtask

  // Monitor: latency on out_valid rise, result compare on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) chk("spurious_valid", 1, 0);
        else begin mon_a = acc_q.pop_front(); chk("latency", cyc - mon_a, W); end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_result", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("D", D, mon_e.d);
          chk("BO", BO, mon_e.bo);
`ifdef SERIAL_SUB_OVF_EN
          chk("OV", OV, mon_e.ov);
`endif
        end
      end
    end
    ov_prev = out_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1);
  end

  initial begin
    int prev;
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; out_ready = 1'b1;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_D", D, 0);
    chk("rst_BO", BO, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("ready_before_edge", in_ready, 0);
    @(negedge clk); chk("ready_after_edge", in_ready, 1);

    // Directed sequence
    send(0, 0); send(1, 0); send(2, 1); send(2, 3); send(3, 3);
    wait_idle();

    // Exhaustive, back-to-back: accepts must be exactly W+2 edges apart
    prev = -1;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        send(W'(a), W'(b));
        if (prev >= 0) chk("period", last_acc - prev, W + 2);
        prev = last_acc;
      end
    wait_idle();

    // in_valid pulse while busy must not be accepted; A/B already scrambled
    send(1, 2);
    @(negedge clk);
    chk("busy_no_ready", in_ready, 0);
    chk("busy_high", busy, 1);
    in_valid = 1'b1; A = 0; B = 0;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_idle();

    // Backpressure
    out_ready = 1'b0;
    send(2, 3);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_valid_seen", out_valid, 1);
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_D", D, 3);
      chk("bp_BO", BO, 1);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_ready_after", in_ready, 1);
    chk("hold_D_idle", D, 3);
    chk("hold_BO_idle", BO, 1);

    // Reset mid-operation aborts without a result
    @(negedge clk);
    in_valid = 1'b1; A = 3; B = 1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); seen |= out_valid; end
    chk("abort_no_valid", seen, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_D", D, 0);
    chk("abort_BO", BO, 0);

    // Signed-overflow corner operands
    send(1, 2); send(2, 1); send(3, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("exp_drain", exp_q.size(), 0);
    chk("acc_drain", acc_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
